// File: rtl/ivs_dma_pkg.sv
// Shared constants and FSM encodings for the DMA core front end.
// Beats are 128 bits wide; bursts are INCR and must not cross a 4 KB line.
package ivs_dma_pkg;

  localparam int BEAT_BYTES     = 16;
  localparam int BEAT_SHIFT     = 4;
  localparam int BOUNDARY_BEATS = 256;

  localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } burst_state_t;

endpackage

// File: rtl/ivs_dma_burst_calc.sv
// Sizes the next burst: the smallest of remaining beats, the max burst length
// and the beats left before the next 4 KB line.
module ivs_dma_burst_calc
  import ivs_dma_pkg::*;
#(
  parameter int REM_W     = 21,
  parameter int MAX_BEATS = 64
) (
  input  logic [7:0]       line_beat,
  input  logic [REM_W-1:0] rem,
  output logic [8:0]       n,
  output logic             last
);

  localparam logic [8:0] MAX_B = 9'(MAX_BEATS);

  logic [8:0] to_bnd_s;
  logic [8:0] cap_s;

  // Burst length is the tightest of the three limits; last when the remainder fits.
  always_comb begin
    to_bnd_s = 9'(BOUNDARY_BEATS) - {1'b0, line_beat};
    if (to_bnd_s < MAX_B) begin
      cap_s = to_bnd_s;
    end else begin
      cap_s = MAX_B;
    end
    if (rem <= REM_W'(cap_s)) begin
      n    = rem[8:0];
      last = 1'b1;
    end else begin
      n    = cap_s;
      last = 1'b0;
    end
  end

endmodule

// File: rtl/ivs_dma_burst_gen_chk.sv
// Protocol properties of the burst request channel: 4 KB rule, length bound,
// and field stability while a burst is stalled.
module ivs_dma_burst_gen_chk #(
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 6,
  parameter int MAX_BEATS = 64
) (
  input logic              aclk,
  input logic              arst,
  input logic              bst_valid,
  input logic              bst_ready,
  input logic [ADDR_W-1:0] bst_addr,
  input logic [LEN_W-1:0]  bst_len,
  input logic [ID_W-1:0]   bst_id,
  input logic              bst_last
);

  p_no_4k_cross: assert property (@(posedge aclk) disable iff (arst)
    bst_valid |-> ((9'({1'b0, bst_addr[11:4]}) + 9'(bst_len)) <= 9'd255));

  p_len_bound: assert property (@(posedge aclk) disable iff (arst)
    bst_valid |-> (32'(bst_len) <= 32'(MAX_BEATS - 1)));

  p_stall_stable: assert property (@(posedge aclk) disable iff (arst)
    (bst_valid && !bst_ready) |=> (bst_valid && $stable(bst_addr) && $stable(bst_len)
                                   && $stable(bst_id) && $stable(bst_last)));

endmodule

// File: rtl/ivs_dma_burst_gen.sv
// Splits a linear transfer command into 4 KB-safe INCR bursts of 128-bit beats,
// one burst per cycle under valid/ready backpressure, with a done pulse at the end.
module ivs_dma_burst_gen
  import ivs_dma_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int BYTES_W   = 24,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 6,
  parameter int MAX_BEATS = 64
) (
  input  logic              aclk,
  input  logic              arst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [BYTES_W-1:0] cmd_bytes,
  input  logic [ID_W-1:0]   cmd_id,
  output logic              bst_valid,
  input  logic              bst_ready,
  output logic [ADDR_W-1:0] bst_addr,
  output logic [LEN_W-1:0]  bst_len,
  output logic [ID_W-1:0]   bst_id,
  output logic              bst_last,
  output logic              cmd_done
);

  localparam int REM_W = BYTES_W - 3;

  burst_state_t      state_r;
  logic [REM_W-1:0]  rem_r;
  logic [8:0]        n_r;
  logic [ADDR_W-1:0] nxt_addr_s;
  logic [REM_W-1:0]  nxt_rem_s;
  logic [REM_W-1:0]  cmd_beats_s;
  logic [8:0]        n_s;
  logic              last_s;
  logic              unused_low_bits_s;

  assign cmd_beats_s       = REM_W'(cmd_bytes[BYTES_W-1:BEAT_SHIFT]);
  assign unused_low_bits_s = ^{cmd_addr[BEAT_SHIFT-1:0], cmd_bytes[BEAT_SHIFT-1:0]};
  assign cmd_ready         = (state_r == ST_IDLE) && !arst;

  // Candidate start of the next burst: a fresh command in IDLE, else the advance past the current one.
  always_comb begin
    nxt_addr_s = bst_addr;
    nxt_rem_s  = rem_r;
    if (state_r == ST_IDLE) begin
      nxt_addr_s = {cmd_addr[ADDR_W-1:BEAT_SHIFT], 4'b0000};
      nxt_rem_s  = cmd_beats_s;
    end else begin
      nxt_addr_s = bst_addr + ADDR_W'({n_r, 4'b0000});
      nxt_rem_s  = rem_r - REM_W'(n_r);
    end
  end

  ivs_dma_burst_calc #(
    .REM_W    (REM_W),
    .MAX_BEATS(MAX_BEATS)
  ) u_calc (
    .line_beat(nxt_addr_s[11:4]),
    .rem      (nxt_rem_s),
    .n        (n_s),
    .last     (last_s)
  );

  // Command/burst FSM; all burst fields are registered and held until accepted.
  always_ff @(posedge aclk) begin
    if (arst) begin
      state_r   <= ST_IDLE;
      rem_r     <= '0;
      n_r       <= 9'd0;
      bst_valid <= 1'b0;
      bst_addr  <= '0;
      bst_len   <= '0;
      bst_id    <= '0;
      bst_last  <= 1'b0;
      cmd_done  <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            bst_id <= cmd_id;
            if (cmd_beats_s == '0) begin
              cmd_done <= 1'b1;
            end else begin
              state_r   <= ST_ISSUE;
              bst_valid <= 1'b1;
              bst_addr  <= nxt_addr_s;
              bst_len   <= LEN_W'(n_s - 9'd1);
              bst_last  <= last_s;
              n_r       <= n_s;
              rem_r     <= nxt_rem_s;
            end
          end
        end
        ST_ISSUE: begin
          if (bst_ready) begin
            if (bst_last) begin
              state_r   <= ST_IDLE;
              bst_valid <= 1'b0;
              cmd_done  <= 1'b1;
            end else begin
              bst_addr <= nxt_addr_s;
              bst_len  <= LEN_W'(n_s - 9'd1);
              bst_last <= last_s;
              n_r      <= n_s;
              rem_r    <= nxt_rem_s;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          bst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ivs_dma_burst_gen.sv
// Bench for ivs_dma_burst_gen: directed scenarios plus random commands and stalls,
// checked against a queue-based burst-splitting reference model.
module tb_ivs_dma_burst_gen;

  typedef struct {
    logic [31:0] a;
    int          len;
    bit          last;
  } bst_t;

  logic        aclk = 1'b0;
  logic        arst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [23:0] cmd_bytes;
  logic [3:0]  cmd_id;
  logic        bst_valid;
  logic        bst_ready;
  logic [31:0] bst_addr;
  logic [5:0]  bst_len;
  logic [3:0]  bst_id;
  logic        bst_last;
  logic        cmd_done;

  int   n_chk  = 0;
  int   n_pass = 0;
  bst_t exp_q[$];

  always #5 aclk = ~aclk;

  ivs_dma_burst_gen dut (
    .aclk(aclk), .arst(arst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_bytes(cmd_bytes), .cmd_id(cmd_id),
    .bst_valid(bst_valid), .bst_ready(bst_ready), .bst_addr(bst_addr),
    .bst_len(bst_len), .bst_id(bst_id), .bst_last(bst_last), .cmd_done(cmd_done)
  );

  ivs_dma_burst_gen_chk u_chk (
    .aclk(aclk), .arst(arst), .bst_valid(bst_valid), .bst_ready(bst_ready),
    .bst_addr(bst_addr), .bst_len(bst_len), .bst_id(bst_id), .bst_last(bst_last)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Reference: walk the byte range, cutting at 64 beats and at every 4 KB line.
  task automatic build_model(input logic [31:0] addr, input logic [23:0] bytes);
    logic [31:0] a;
    int rem, bnd, n;
    exp_q.delete();
    a   = addr & 32'hFFFF_FFF0;
    rem = int'(bytes) / 16;
    while (rem > 0) begin
      bnd = (4096 - int'(a % 32'd4096)) / 16;
      n   = rem;
      if (n > 64) n = 64;
      if (n > bnd) n = bnd;
      exp_q.push_back('{a: a, len: n - 1, last: (n == rem)});
      a   = a + 32'(n * 16);
      rem = rem - n;
    end
  endtask

  task automatic check_burst(input string tag, input bst_t e, input logic [3:0] id);
    check_val({tag, ".valid"}, 64'(bst_valid), 64'd1);
    check_val({tag, ".addr"},  64'(bst_addr),  64'(e.a));
    check_val({tag, ".len"},   64'(bst_len),   64'(e.len));
    check_val({tag, ".id"},    64'(bst_id),    64'(id));
    check_val({tag, ".last"},  64'(bst_last),  64'(e.last));
    check_val({tag, ".done"},  64'(cmd_done),  64'd0);
  endtask

  task automatic accept_cmd(input logic [31:0] addr, input logic [23:0] bytes, input logic [3:0] id);
    int waitc;
    waitc = 0;
    while (!cmd_ready && waitc < 20) begin
      step();
      waitc++;
    end
    check_val("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_bytes = bytes;
    cmd_id    = id;
    step();
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_bytes = 24'($urandom);
    cmd_id    = 4'($urandom);
  endtask

  task automatic run_cmd(input logic [31:0] addr, input logic [23:0] bytes, input logic [3:0] id,
                         input int stall_pct, input int stall_burst, input int stall_len);
    int stalls;
    build_model(addr, bytes);
    accept_cmd(addr, bytes, id);
    if (exp_q.size() == 0) begin
      check_val("empty.done",  64'(cmd_done),  64'd1);
      check_val("empty.valid", 64'(bst_valid), 64'd0);
      check_val("empty.ready", 64'(cmd_ready), 64'd1);
      return;
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k == stall_burst) stalls = stall_len;
      else if (int'($urandom_range(99)) < stall_pct) stalls = int'($urandom_range(1, 3));
      else stalls = 0;
      for (int s = 0; s < stalls; s++) begin
        check_burst($sformatf("stall%0d_%0d", k, s), exp_q[k], id);
        bst_ready = 1'b0;
        step();
      end
      check_burst($sformatf("burst%0d", k), exp_q[k], id);
      check_val($sformatf("burst%0d.cmd_ready", k), 64'(cmd_ready), 64'd0);
      bst_ready = 1'b1;
      step();
      bst_ready = 1'b0;
    end
    check_val("end.valid", 64'(bst_valid), 64'd0);
    check_val("end.done",  64'(cmd_done),  64'd1);
    check_val("end.ready", 64'(cmd_ready), 64'd1);
    step();
    check_val("end.done_pulse", 64'(cmd_done), 64'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [23:0] b;
    arst      = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_bytes = '0;
    cmd_id    = '0;
    bst_ready = 1'b0;
    step();
    step();
    check_val("rst.ready", 64'(cmd_ready), 64'd0);
    check_val("rst.valid", 64'(bst_valid), 64'd0);
    check_val("rst.addr",  64'(bst_addr),  64'd0);
    check_val("rst.len",   64'(bst_len),   64'd0);
    check_val("rst.id",    64'(bst_id),    64'd0);
    check_val("rst.last",  64'(bst_last),  64'd0);
    check_val("rst.done",  64'(cmd_done),  64'd0);
    arst = 1'b0;
    step();
    check_val("post_rst.ready", 64'(cmd_ready), 64'd1);

    run_cmd(32'h0000_1000, 24'h000400, 4'd5, 0, -1, 0);
    run_cmd(32'h0000_0FC0, 24'h000100, 4'd2, 0, -1, 0);
    run_cmd(32'h0000_2000, 24'h001010, 4'd7, 0, -1, 0);
    run_cmd(32'h0000_2000, 24'h001010, 4'd9, 0, 1, 5);
    run_cmd(32'h0000_5000, 24'h000000, 4'd3, 0, -1, 0);
    run_cmd(32'h0000_6008, 24'h00002F, 4'd4, 0, -1, 0);
    run_cmd(32'hFFFF_FF00, 24'h000200, 4'd1, 0, -1, 0);

    // Reset while the second burst is on offer drops the command.
    build_model(32'h0000_2000, 24'h001010);
    accept_cmd(32'h0000_2000, 24'h001010, 4'd6);
    check_burst("arst.b0", exp_q[0], 4'd6);
    bst_ready = 1'b1;
    step();
    bst_ready = 1'b0;
    check_burst("arst.b1", exp_q[1], 4'd6);
    arst = 1'b1;
    step();
    check_val("arst.valid", 64'(bst_valid), 64'd0);
    check_val("arst.done",  64'(cmd_done),  64'd0);
    check_val("arst.ready", 64'(cmd_ready), 64'd0);
    arst      = 1'b0;
    bst_ready = 1'b1;
    step();
    check_val("arst_after.ready", 64'(cmd_ready), 64'd1);
    check_val("arst_after.valid", 64'(bst_valid), 64'd0);
    bst_ready = 1'b0;
    run_cmd(32'h0000_3F00, 24'h000800, 4'd11, 0, -1, 0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      case ($urandom_range(3))
        0: begin a = r; b = 24'($urandom_range(15)); end
        1: begin a = r; b = 24'($urandom_range(0, 32'h1000)); end
        2: begin a = r; b = 24'($urandom_range(0, 32'h8000)); end
        default: begin a = r | 32'h0000_0FC0; b = 24'($urandom_range(0, 32'h0600)); end
      endcase
      run_cmd(a, b, 4'($urandom), int'($urandom_range(0, 60)), -1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
